// File: rtl/apb_mc_transceiver.sv
// apb_mc_transceiver: NCH-channel APB slave bridging per-channel TX/RX FIFOs to valid/halt streams,
// with per-channel control, sticky error status and a registered combined interrupt.
module apb_mc_transceiver #(
   parameter int NCH    = 2,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_psel,
   input  logic                   i_penable,
   input  logic                   i_pwrite,
   input  logic [$clog2(NCH)+3:0] i_paddr,
   input  logic [31:0]            i_pwdata,
   output logic [31:0]            o_prdata,
   output logic [NCH*DATA_W-1:0]  o_tx_data,
   output logic [NCH-1:0]         o_tx_valid,
   input  logic [NCH-1:0]         i_tx_halt,
   input  logic [NCH*DATA_W-1:0]  i_rx_data,
   input  logic [NCH-1:0]         i_rx_valid,
   output logic [NCH-1:0]         o_rx_halt,
   output logic                   o_irq
);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int PW = $clog2(DEPTH);
   localparam int NW = PW + 1;

   logic [CW-1:0]  w_ch;
   logic [3:0]     w_off;
   logic           w_wr, w_rd, r_irq, w_unused;
   logic [31:0]    w_rdata [2**CW];
   logic [NCH-1:0] w_int;

   assign w_off    = i_paddr[3:0];
   assign w_wr     = i_psel & i_penable & i_pwrite;
   assign w_rd     = i_psel & i_penable & ~i_pwrite;
   assign w_unused = ^i_pwdata;
   assign o_prdata = (i_psel & ~i_pwrite) ? w_rdata[w_ch] : 32'h0;
   assign o_irq    = r_irq;

   if (NCH > 1) begin : g_chsel
      assign w_ch = i_paddr[$clog2(NCH)+3:4];
   end else begin : g_chone
      assign w_ch = 1'b0;
   end

   // Channel slots beyond NCH exist only so out-of-range indices decode to a zero read.
   for (genvar c = 0; c < 2**CW; c++) begin : g_ch
      if (c < NCH) begin : g_on
         logic [DATA_W-1:0] r_tx_mem [DEPTH];
         logic [DATA_W-1:0] r_rx_mem [DEPTH];
         logic [PW-1:0]     r_tx_rp, r_tx_wp, r_rx_rp, r_rx_wp;
         logic [NW-1:0]     r_tx_cnt, r_rx_cnt;
         logic [3:0]        r_ctrl;
         logic              r_tx_ovf, r_rx_udf;
         logic              w_hit, w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
         logic              w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_tx_drop, w_rx_miss;
         logic [31:0]       w_status;

         assign w_hit      = w_ch == CW'(c);
         assign w_tx_empty = r_tx_cnt == '0;
         assign w_tx_full  = r_tx_cnt == NW'(DEPTH);
         assign w_rx_empty = r_rx_cnt == '0;
         assign w_rx_full  = r_rx_cnt == NW'(DEPTH);
         assign w_tx_drop  = w_wr & w_hit & (w_off == 4'h0) & w_tx_full;
         assign w_tx_push  = w_wr & w_hit & (w_off == 4'h0) & ~w_tx_full;
         assign w_tx_pop   = o_tx_valid[c] & ~i_tx_halt[c];
         assign w_rx_miss  = w_rd & w_hit & (w_off == 4'h4) & w_rx_empty;
         assign w_rx_pop   = w_rd & w_hit & (w_off == 4'h4) & ~w_rx_empty;
         assign w_rx_push  = i_rx_valid[c] & ~w_rx_full;

         assign o_tx_valid[c]                  = r_ctrl[0] & ~w_tx_empty;
         assign o_tx_data[c*DATA_W +: DATA_W]  = w_tx_empty ? '0 : r_tx_mem[r_tx_rp];
         assign o_rx_halt[c]                   = w_rx_full;
         assign w_int[c] = (r_ctrl[1] & ~w_rx_empty) | (r_ctrl[2] & w_tx_empty) |
                           (r_ctrl[3] & (r_tx_ovf | r_rx_udf));

         assign w_status = {8'h0, 8'(r_rx_cnt), 8'(r_tx_cnt), 2'b0, r_rx_udf, r_tx_ovf,
                            w_rx_full, w_rx_empty, w_tx_full, w_tx_empty};
         assign w_rdata[c] = (w_off == 4'h4) ? (w_rx_empty ? 32'h0 : 32'(r_rx_mem[r_rx_rp])) :
                             (w_off == 4'h8) ? w_status :
                             (w_off == 4'hC) ? {28'h0, r_ctrl} : 32'h0;

         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               r_tx_rp  <= '0;
               r_tx_wp  <= '0;
               r_rx_rp  <= '0;
               r_rx_wp  <= '0;
               r_tx_cnt <= '0;
               r_rx_cnt <= '0;
               r_ctrl   <= '0;
               r_tx_ovf <= 1'b0;
               r_rx_udf <= 1'b0;
            end else begin
               if (w_tx_push) r_tx_wp <= r_tx_wp + PW'(1);
               if (w_tx_pop)  r_tx_rp <= r_tx_rp + PW'(1);
               if (w_rx_push) r_rx_wp <= r_rx_wp + PW'(1);
               if (w_rx_pop)  r_rx_rp <= r_rx_rp + PW'(1);
               r_tx_cnt <= r_tx_cnt + NW'(w_tx_push) - NW'(w_tx_pop);
               r_rx_cnt <= r_rx_cnt + NW'(w_rx_push) - NW'(w_rx_pop);
               if (w_wr & w_hit & (w_off == 4'hC)) r_ctrl <= i_pwdata[3:0];
               r_tx_ovf <= w_tx_drop | (r_tx_ovf & ~(w_wr & w_hit & (w_off == 4'h8) & i_pwdata[4]));
               r_rx_udf <= w_rx_miss | (r_rx_udf & ~(w_wr & w_hit & (w_off == 4'h8) & i_pwdata[5]));
            end
         end

         // Storage is not reset: occupancy lives in the counts, and tx_data is gated while empty.
         always_ff @(posedge i_clk) begin
            if (w_tx_push) r_tx_mem[r_tx_wp] <= i_pwdata[DATA_W-1:0];
            if (w_rx_push) r_rx_mem[r_rx_wp] <= i_rx_data[c*DATA_W +: DATA_W];
         end
      end else begin : g_off
         assign w_rdata[c] = 32'h0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_irq <= 1'b0;
      else       r_irq <= |w_int;
   end
endmodule

// File: tb/tb_apb_mc_transceiver.sv
// tb_apb_mc_transceiver: directed and randomized checks of apb_mc_transceiver against a queue-based model.
module tb_apb_mc_transceiver;
   localparam int NCH = 2, DW = 8, DEPTH = 4;

   logic        clk, rst, psel, penable, pwrite, irq;
   logic [4:0]  paddr;
   logic [31:0] pwdata, prdata;
   logic [15:0] tx_data, rx_data;
   logic [1:0]  tx_valid, tx_halt, rx_valid, rx_halt;
   int          n_checks, n_fail;

   logic [7:0] tq [2][$];
   logic [7:0] rq [2][$];
   logic [3:0] m_ctrl [2];
   logic       m_ovf [2], m_udf [2];
   logic       m_irq;

   apb_mc_transceiver #(.NCH(NCH), .DATA_W(DW), .DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst(rst), .i_psel(psel), .i_penable(penable), .i_pwrite(pwrite),
      .i_paddr(paddr), .i_pwdata(pwdata), .o_prdata(prdata), .o_tx_data(tx_data),
      .o_tx_valid(tx_valid), .i_tx_halt(tx_halt), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
      .o_rx_halt(rx_halt), .o_irq(irq));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         tq[c].delete(); rq[c].delete();
         m_ctrl[c] = 4'h0; m_ovf[c] = 1'b0; m_udf[c] = 1'b0;
      end
      m_irq = 1'b0;
   endtask

   function automatic logic m_int(int c);
      return (m_ctrl[c][1] && rq[c].size() != 0) || (m_ctrl[c][2] && tq[c].size() == 0) ||
             (m_ctrl[c][3] && (m_ovf[c] || m_udf[c]));
   endfunction

   function automatic logic [31:0] m_status(int c);
      int t = tq[c].size();
      int r = rq[c].size();
      return {8'h0, 8'(r), 8'(t), 2'b0, m_udf[c], m_ovf[c], r == DEPTH, r == 0, t == DEPTH, t == 0};
   endfunction

   function automatic logic [31:0] m_prdata();
      int c = int'(paddr[4]);
      if (!psel || pwrite) return 32'h0;
      case (paddr[3:0])
         4'h4:    return rq[c].size() != 0 ? 32'(rq[c][0]) : 32'h0;
         4'h8:    return m_status(c);
         4'hC:    return 32'(m_ctrl[c]);
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [1:0] m_txv();
      logic [1:0] v;
      for (int c = 0; c < 2; c++) v[c] = m_ctrl[c][0] && tq[c].size() != 0;
      return v;
   endfunction

   function automatic logic [1:0] m_rxh();
      logic [1:0] v;
      for (int c = 0; c < 2; c++) v[c] = rq[c].size() == DEPTH;
      return v;
   endfunction

   // Advance one clock edge, applying the register-map and stream rules to the model.
   task automatic tick();
      logic nirq, xw, xr, tfull, rfull;
      int ch;
      logic [3:0] o;
      @(posedge clk);
      if (rst) model_reset();
      else begin
         nirq = m_int(0) || m_int(1);
         xw = psel && penable && pwrite;
         xr = psel && penable && !pwrite;
         ch = int'(paddr[4]);
         o = paddr[3:0];
         for (int c = 0; c < 2; c++) begin
            tfull = tq[c].size() == DEPTH;
            rfull = rq[c].size() == DEPTH;
            if (m_ctrl[c][0] && tq[c].size() != 0 && !tx_halt[c]) void'(tq[c].pop_front());
            if (ch == c && xw && o == 4'h0) begin
               if (tfull) m_ovf[c] = 1'b1;
               else tq[c].push_back(pwdata[7:0]);
            end
            if (ch == c && xr && o == 4'h4) begin
               if (rq[c].size() == 0) m_udf[c] = 1'b1;
               else void'(rq[c].pop_front());
            end
            if (rx_valid[c] && !rfull) rq[c].push_back(rx_data[c*8 +: 8]);
            if (ch == c && xw && o == 4'h8) begin
               if (pwdata[4]) m_ovf[c] = 1'b0;
               if (pwdata[5]) m_udf[c] = 1'b0;
            end
            if (ch == c && xw && o == 4'hC) m_ctrl[c] = pwdata[3:0];
         end
         m_irq = nirq;
      end
      #1;
   endtask

   task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
      tick();
      penable = 1'b1;
      tick();
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [4:0] a, output logic [31:0] got, output logic [31:0] exp);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
      tick();
      penable = 1'b1;
      #1;
      got = prdata;
      exp = m_prdata();
      tick();
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      tx_halt = '0; rx_valid = '0; rx_data = '0;
      tick(); tick();
      #1;
      n_checks++; if (tx_valid !== 2'b00) begin n_fail++; $display("FAIL reset_tx_valid got %b exp 00", tx_valid); end
      n_checks++; if (rx_halt !== 2'b00) begin n_fail++; $display("FAIL reset_rx_halt got %b exp 00", rx_halt); end
      n_checks++; if (tx_data !== 16'h0) begin n_fail++; $display("FAIL reset_tx_data got %h exp 0000", tx_data); end
      n_checks++; if (prdata !== 32'h0) begin n_fail++; $display("FAIL reset_prdata got %h exp 0", prdata); end
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b exp 0", irq); end
      rst = 1'b0;
      tick();
      apb_write(5'h0C, 32'h1);
      apb_write(5'h00, 32'hA5);
      #1;
      n_checks++; if (tx_valid[0] !== 1'b1 || tx_data[7:0] !== 8'hA5)
         begin n_fail++; $display("FAIL first_beat got v=%b d=%h exp v=1 d=a5", tx_valid[0], tx_data[7:0]); end
      tick();
      #1;
      n_checks++; if (tx_valid[0] !== 1'b0) begin n_fail++; $display("FAIL first_beat_drain got %b exp 0", tx_valid[0]); end
   endtask

   task automatic test_tx_overflow();
      logic [31:0] got, exp;
      apb_write(5'h1C, 32'h0);
      for (int i = 1; i <= 5; i++) apb_write(5'h10, 32'(i));
      apb_read(5'h18, got, exp);
      n_checks++; if (got !== 32'h416) begin n_fail++; $display("FAIL ovf_status got %h exp 00000416", got); end
      apb_write(5'h1C, 32'h1);
      for (int i = 1; i <= 4; i++) begin
         #1;
         n_checks++; if (tx_valid[1] !== 1'b1 || tx_data[15:8] !== 8'(i))
            begin n_fail++; $display("FAIL ovf_stream[%0d] got v=%b d=%h exp v=1 d=%h", i, tx_valid[1], tx_data[15:8], 8'(i)); end
         tick();
      end
      #1;
      n_checks++; if (tx_valid[1] !== 1'b0) begin n_fail++; $display("FAIL ovf_stream_end got %b exp 0", tx_valid[1]); end
      apb_write(5'h18, 32'h10);
      apb_read(5'h18, got, exp);
      n_checks++; if (got !== 32'h5 || got !== exp) begin n_fail++; $display("FAIL ovf_clear got %h exp 00000005", got); end
   endtask

   task automatic test_tx_halt();
      logic [7:0] d [4];
      logic [7:0] got [$];
      logic [7:0] hold;
      tx_halt = 2'b01;
      for (int i = 0; i < 4; i++) begin
         d[i] = 8'($urandom);
         apb_write(5'h00, {24'h0, d[i]});
      end
      tx_halt = 2'b00;
      #1;
      if (tx_valid[0]) got.push_back(tx_data[7:0]);
      tick();
      tx_halt = 2'b01;
      #1;
      hold = tx_data[7:0];
      n_checks++; if (hold !== d[1]) begin n_fail++; $display("FAIL halt_head got %h exp %h", hold, d[1]); end
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (tx_valid[0] !== 1'b1 || tx_data[7:0] !== hold)
            begin n_fail++; $display("FAIL halt_stable[%0d] got v=%b d=%h exp v=1 d=%h", i, tx_valid[0], tx_data[7:0], hold); end
         tick();
         #1;
      end
      tx_halt = 2'b00;
      for (int i = 0; i < 5; i++) begin
         if (tx_valid[0]) got.push_back(tx_data[7:0]);
         tick();
         #1;
      end
      n_checks++; if (got.size() != 4) begin n_fail++; $display("FAIL halt_beats got %0d exp 4", got.size()); end
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         n_checks++; if (got[i] !== d[i]) begin n_fail++; $display("FAIL halt_order[%0d] got %h exp %h", i, got[i], d[i]); end
      end
   endtask

   task automatic test_rx_fill();
      logic [31:0] got, exp;
      logic [7:0] e [4];
      e = '{8'h22, 8'h33, 8'h44, 8'h55};
      rx_valid = 2'b01;
      for (int i = 0; i < 4; i++) begin
         rx_data[7:0] = 8'(17 * (i + 1));
         tick();
      end
      rx_data[7:0] = 8'h55;
      #1;
      n_checks++; if (rx_halt[0] !== 1'b1) begin n_fail++; $display("FAIL rx_full_halt got %b exp 1", rx_halt[0]); end
      tick(); tick();
      apb_read(5'h04, got, exp);
      n_checks++; if (got !== 32'h11 || got !== exp) begin n_fail++; $display("FAIL rx_first got %h exp 00000011", got); end
      #1;
      n_checks++; if (rx_halt[0] !== 1'b0) begin n_fail++; $display("FAIL rx_halt_release got %b exp 0", rx_halt[0]); end
      tick();
      rx_valid = 2'b00;
      #1;
      n_checks++; if (rx_halt[0] !== 1'b1) begin n_fail++; $display("FAIL rx_fifth_accept got %b exp 1", rx_halt[0]); end
      for (int i = 0; i < 4; i++) begin
         apb_read(5'h04, got, exp);
         n_checks++; if (got !== 32'(e[i]) || got !== exp)
            begin n_fail++; $display("FAIL rx_drain[%0d] got %h exp %h", i, got, 32'(e[i])); end
      end
      apb_read(5'h04, got, exp);
      n_checks++; if (got !== 32'h0) begin n_fail++; $display("FAIL rx_empty_read got %h exp 0", got); end
      apb_read(5'h08, got, exp);
      n_checks++; if (got !== 32'h25 || got !== exp) begin n_fail++; $display("FAIL rx_udf_status got %h exp 00000025", got); end
      apb_write(5'h08, 32'h20);
   endtask

   task automatic test_irq_isolation();
      logic [31:0] got, exp;
      logic [7:0] b;
      apb_write(5'h1C, 32'h3);
      rx_valid = 2'b01; rx_data[7:0] = 8'($urandom);
      tick();
      rx_valid = 2'b00;
      tick(); tick();
      #1;
      n_checks++; if (irq !== 1'b0 || irq !== m_irq) begin n_fail++; $display("FAIL irq_ch0_masked got %b exp 0", irq); end
      b = 8'($urandom);
      rx_valid = 2'b10; rx_data[15:8] = b;
      tick();
      rx_valid = 2'b00;
      #1;
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_latency got %b exp 0", irq); end
      tick();
      #1;
      n_checks++; if (irq !== 1'b1 || irq !== m_irq) begin n_fail++; $display("FAIL irq_ch1_set got %b exp 1", irq); end
      apb_read(5'h14, got, exp);
      n_checks++; if (got !== 32'(b) || got !== exp) begin n_fail++; $display("FAIL irq_ch1_read got %h exp %h", got, 32'(b)); end
      #1;
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold got %b exp 1", irq); end
      tick();
      #1;
      n_checks++; if (irq !== 1'b0 || irq !== m_irq) begin n_fail++; $display("FAIL irq_clear got %b exp 0", irq); end
   endtask

   task automatic test_random();
      logic [1:0] ev;
      for (int n = 0; n < 500; n++) begin
         tx_halt = 2'($urandom); rx_valid = 2'($urandom); rx_data = 16'($urandom);
         if (!psel) begin
            if ($urandom_range(0, 3) != 0) begin
               psel = 1'b1; penable = 1'b0; pwrite = 1'($urandom);
               paddr = {1'($urandom), 2'($urandom), 2'($urandom_range(0, 7) == 0 ? $urandom : 0)};
               pwdata = $urandom;
            end
         end else if (!penable) penable = 1'b1;
         else begin psel = 1'b0; penable = 1'b0; end
         #1;
         ev = m_txv();
         n_checks++; if (tx_valid !== ev) begin n_fail++; $display("FAIL rnd_tx_valid[%0d] got %b exp %b", n, tx_valid, ev); end
         ev = m_rxh();
         n_checks++; if (rx_halt !== ev) begin n_fail++; $display("FAIL rnd_rx_halt[%0d] got %b exp %b", n, rx_halt, ev); end
         n_checks++; if (irq !== m_irq) begin n_fail++; $display("FAIL rnd_irq[%0d] got %b exp %b", n, irq, m_irq); end
         n_checks++; if (prdata !== m_prdata()) begin n_fail++; $display("FAIL rnd_prdata[%0d] got %h exp %h", n, prdata, m_prdata()); end
         for (int c = 0; c < 2; c++) if (tx_valid[c] && tq[c].size() != 0) begin
            n_checks++; if (tx_data[c*8 +: 8] !== tq[c][0])
               begin n_fail++; $display("FAIL rnd_tx_data[%0d] ch%0d got %h exp %h", n, c, tx_data[c*8 +: 8], tq[c][0]); end
         end
         tick();
      end
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; tx_halt = '0; rx_valid = '0;
      tick();
   endtask

   task automatic test_reset_mid();
      logic [31:0] got, exp;
      apb_write(5'h0C, 32'h1);
      apb_write(5'h1C, 32'h2);
      tx_halt = 2'b11;
      apb_write(5'h00, 32'h3C);
      apb_write(5'h00, 32'hC3);
      rx_valid = 2'b10;
      for (int i = 0; i < 6; i++) begin rx_data = 16'($urandom); tick(); end
      #1;
      n_checks++; if (tx_valid[0] !== 1'b1 || rx_halt[1] !== 1'b1 || irq !== 1'b1)
         begin n_fail++; $display("FAIL mid_setup got v=%b h=%b i=%b exp 1 1 1", tx_valid[0], rx_halt[1], irq); end
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      n_checks++; if (tx_valid !== 2'b00) begin n_fail++; $display("FAIL mid_tx_valid got %b exp 00", tx_valid); end
      n_checks++; if (rx_halt !== 2'b00) begin n_fail++; $display("FAIL mid_rx_halt got %b exp 00", rx_halt); end
      n_checks++; if (tx_data !== 16'h0) begin n_fail++; $display("FAIL mid_tx_data got %h exp 0000", tx_data); end
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_irq got %b exp 0", irq); end
      rx_valid = 2'b00; tx_halt = 2'b00;
      tick();
      rst = 1'b0;
      tick();
      apb_read(5'h08, got, exp);
      n_checks++; if (got !== 32'h5 || got !== exp) begin n_fail++; $display("FAIL mid_status0 got %h exp 00000005", got); end
      apb_read(5'h18, got, exp);
      n_checks++; if (got !== 32'h5 || got !== exp) begin n_fail++; $display("FAIL mid_status1 got %h exp 00000005", got); end
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      model_reset();
      test_reset();
      test_tx_overflow();
      test_tx_halt();
      test_rx_fill();
      test_irq_isolation();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/apb_mc_transceiver.md
# apb_mc_transceiver

Multi-channel APB transceiver: the parametrised successor of the single-channel APB transceiver. It provides NCH independent channels. Each channel has a TX FIFO, an RX FIFO, per-channel control/status registers and interrupt enables, all behind one zero-wait APB slave. Each channel's TX side drives a valid/halt stream sink and its RX side accepts a valid/halt stream source. A single combined irq goes to the interrupt monitor. It sits between the APB bus and NCH tx_rx stream interfaces.

## Interface
- NCH, 2: number of channels, 1..8
- DATA_W, 8: stream data width, 1..32
- DEPTH, 4: entries per FIFO (TX and RX each), power of 2, ≥2
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- psel  in  1  APB select
- penable  in  1  APB enable (access phase)
- pwrite  in  1  APB write
- paddr  in  $clog2(NCH)+4  byte address: [3:0] register offset, upper bits channel index
- pwdata  in  32  APB write data
- prdata  out  32  APB read data
- tx_data  out  NCH*DATA_W  per-channel TX data, channel c at [c*DATA_W +: DATA_W]
- tx_valid  out  NCH  per-channel TX valid
- tx_halt  in  NCH  per-channel sink stall
- rx_data  in  NCH*DATA_W  per-channel RX data
- rx_valid  in  NCH  per-channel RX valid
- rx_halt  out  NCH  per-channel RX stall to source
- irq  out  1  combined interrupt

## Operation
- **APB access.**
  - A transfer occurs when psel & penable. Zero wait states; there is no pready.
  - Writes take effect on the clock edge ending the access phase.
  - prdata is combinational during psel & !pwrite and is 0 otherwise.
- **Register map, per channel** (channel c at base c*16):
  - 0x0 TXDATA (W): push pwdata[DATA_W-1:0] into the TX FIFO. If the FIFO is full, the data is dropped and tx_ovf is set. Reads return 0.
  - 0x4 RXDATA (R): returns the RX FIFO head, zero-extended, and pops it in the access phase. If the FIFO is empty, returns 0, no pop, and rx_udf is set. Writes are ignored.
  - 0x8 STATUS (R): [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [4] tx_ovf, [5] rx_udf, [15:8] tx_count, [23:16] rx_count. Writing 1 to bit 4 or 5 clears that sticky bit.
  - 0xC CTRL (R/W): [0] tx_en, [1] ie_rxne, [2] ie_txe, [3] ie_err. Other bits read 0.
- Unmapped offsets and channel index ≥ NCH: reads return 0, writes are ignored.
- **TX stream, per channel.**
  - tx_valid = tx_en & !tx_empty.
  - tx_data = TX FIFO head.
  - A beat transfers and the FIFO pops on an edge where tx_valid & !tx_halt.
  - While halted, data and valid are held stable.
  - Clearing tx_en drops tx_valid in the same cycle; FIFO contents are kept.
- **RX stream, per channel.**
  - rx_halt = rx_full.
  - A beat is accepted on an edge where rx_valid & !rx_halt.
  - Data is never dropped on the RX side.
- **Simultaneous events.**
  - TX: a push while full is dropped even if a pop happens in the same cycle. A push and pop with the FIFO not full leaves the count unchanged.
  - RX: a pop and an accept in the same cycle leave the count unchanged.
- **Interrupt.** Per channel, int_c = (ie_rxne & !rx_empty) | (ie_txe & tx_empty) | (ie_err & (tx_ovf | rx_udf)). irq is a register holding OR over c of int_c.
- **Widths.** Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Counts are $clog2(DEPTH)+1 bits.

## Timing
- **Reset values.**
  - Reset asserted: all FIFOs empty, pointers 0, CTRL = 0, sticky bits 0, irq = 0.
  - Outputs: tx_valid = 0, rx_halt = 0, tx_data = 0, prdata = 0.
  - Reset asserted mid-transfer aborts it immediately; FIFO contents are lost.
- **Latencies.**
  - TXDATA write to tx_valid: 1 cycle, provided tx_en = 1 and the FIFO was empty.
  - RX accept to data readable via RXDATA: available in the next cycle's access phase.
  - Condition change to irq: 1 cycle.
  - rx_halt asserts in the cycle after the accept that fills the FIFO. It deasserts in the cycle after the pop.
  - STATUS reflects state as of the start of the access phase.
- **Back-to-back throughput.** TX streams 1 beat/cycle when unhalted. RX accepts 1 beat/cycle while not full.

## Test plan
- **Reset.** Check every output after reset. Then write CTRL ch0 = 0x1 and TXDATA ch0 = 0xA5 -> tx_valid[0] = 1 and tx_data[7:0] = 0xA5 after 1 cycle; with tx_halt = 0, tx_valid[0] = 0 on the following cycle.
- **TX overflow.** Set tx_en = 0 and write 5 bytes 0x01..0x05 to ch1, DEPTH = 4 -> STATUS = tx_full, tx_count = 4, tx_ovf = 1. Then enable -> stream 0x01..0x04 in order. Then write STATUS = 0x10 -> tx_ovf clears.
- **TX halt.** Hold tx_halt[0] = 1 for 3 cycles mid-stream -> tx_data and tx_valid stay stable. Release -> no beat lost or duplicated.
- **RX fill and underflow.** Drive 4 beats 0x11..0x44 on ch0 -> rx_halt[0] = 1 with a 5th beat held on rx_valid. Read RXDATA -> 0x11; rx_halt drops and the 5th beat is accepted. Then drain 4 reads. A 6th read returns 0 and sets rx_udf.
- **Interrupts and channel isolation.** Enable ie_rxne on ch1 only and drive an RX beat on ch0 -> irq = 0. Drive an RX beat on ch1 -> irq = 1 one cycle later; it clears one cycle after the ch1 RXDATA read empties the FIFO.
- **Reset mid-stream.** Assert reset mid-stream with FIFOs partially full -> all outputs reset immediately. After release, STATUS shows both FIFOs empty.
